arbitro_rr_mux16: RTL and testbench
===================================

Name: arbitro_rr_mux16

Overview:
Round-robin arbiter that shares one 16:1 × 12-bit selection path among 16 requesters. It picks one requesting source and drives the 4-bit select. It latches the chosen 12-bit word and presents it to a single consumer over a valid/ready handshake. When the consumer accepts, it pulses a one-hot acknowledge back to the served requester. It sits between the register/data sources and the shared datapath consumer in the lab datapath.

Parameters:
N, 16, number of requesters (fixed; only 16 is supported)
W, 12, data word width
SELW, 4, select width (log2 N)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req  input  16  request per source; bit i = source i
dado  input  192  packed source data; source i occupies bits [12i+11:12i]
pronto  input  1  consumer ready
sel  output  4  index of the granted source
saida  output  12  latched data word of the granted source
valido  output  1  saida/sel hold a transfer not yet accepted
ack  output  16  one-hot; bit sel is high during the accept cycle only

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low, sampled on the clock rising edge.
- Reset values: sel=0, saida=0, valido=0, ack=0, state=OCIOSO. The priority pointer ptr=0, so source 0 has first priority.
- State OCIOSO:
  - If req==0, stay and keep valido=0.
  - Otherwise, choose idx = first set bit of req searching ptr, ptr+1, … 15, 0, … ptr-1 (wrap-around).
  - At the edge, register sel=idx, saida=dado[idx], valido=1, and go to ENVIA.
  - Latency: req asserted at edge k gives valido=1 after edge k+1.
- State ENVIA:
  - sel and saida are held stable while valido=1 and pronto=0. There is no timeout.
  - Later changes to dado[sel] do not affect saida, because the data was captured at grant.
  - Deassertion of req[sel] during ENVIA does not retract the grant; the transfer still completes.
  - Accept cycle is valido=1 and pronto=1.
  - ack is combinational: ack = valido & pronto ? (1 << sel) : 0.
  - At the edge ending the accept cycle: valido=0, ptr = sel+1 mod 16 (15 wraps to 0), state returns to OCIOSO.
  - sel and saida keep their last values while valido=0.
- Requester contract: a requester drops req at the edge where it sees ack, unless it has another word to send. A req still high is treated as a new request.
- Throughput: at most one transfer per 2 cycles, because of the OCIOSO bubble.
- Fairness: a continuously asserted req is served within at most 16 accepted transfers.
- pronto with valido=0: ignored; ack stays 0.
- Simultaneous requests: resolved only by ptr rotation. There is no fixed priority beyond that.
- Reset mid-transfer:
  - reset=0 during ENVIA aborts the transfer, and no ack is issued in that cycle.
  - All registers take their reset values at that edge.
  - ptr returns to 0.

Decomposition:
- Shared package arbitro_pkg holds:
  - constants N=16, W=12, SELW=4;
  - state enum {OCIOSO, ENVIA};
  - a helper function to slice word i from the packed dado bus.
- One sub-module: codificador_prio_rr. It is combinational; its inputs are req[15:0] and ptr[3:0], its outputs are idx[3:0] and any.
- The top level contains the FSM, ptr, and the output registers.

Test Plan:
- Reset, then req=16'h0001, dado[0]=12'hABC, pronto=1: valido=1, sel=0, saida=12'hABC one cycle after grant; ack=16'h0001 for exactly one cycle; ptr becomes 1.
- req=16'hFFFF held, pronto=1 continuously: sel sequence 0,1,2,…,15,0. One ack every 2 cycles, and each ack bit is seen exactly once per 16 transfers.
- ptr=15 (after serving 14), req=16'h8001: source 15 is granted first, then source 0 (wrap-around); ack order 16'h8000, 16'h0001.
- Grant source 3 with dado[3]=12'h123, then change dado[3] to 12'h456 and hold pronto=0 for 5 cycles: saida stays 12'h123, ack stays 0. Raise pronto: ack=16'h0008 for one cycle.
- Grant source 5, then drop req[5] while pronto=0: valido stays 1 and sel=5. After pronto=1, ack=16'h0020 and valido falls.
- Grant source 7, hold pronto=0, assert reset=0 for one cycle: next cycle valido=0, ack=0, sel=0, saida=0. With req=16'h0081, source 0 is granted next.

Source files
------------

// File: rtl/arbitro_rr_mux16_pkg.sv
// Shared constants, FSM states and the source-word slicer for the 16-way round-robin mux.
// Pure declarations: no latency and no backpressure of its own.
package arbitro_pkg;

  localparam int N    = 16;
  localparam int W    = 12;
  localparam int SELW = 4;

  typedef enum logic {
    OCIOSO,
    ENVIA
  } estado_t;

  function automatic logic [W-1:0] palavra(input logic [N*W-1:0] dado,
                                           input logic [SELW-1:0] i);
    return dado[i*W +: W];
  endfunction

endpackage

// File: rtl/arbitro_rr_mux16_if.sv
// Handshake/data bundle between the 16 sources, the arbiter and its single consumer.
// Carries no state: latency and backpressure belong to the arbiter (pronto stalls valido).
interface arbitro_rr_mux16_if;
  import arbitro_pkg::*;

  logic [N-1:0]    req;
  logic [N*W-1:0]  dado;
  logic            pronto;
  logic [SELW-1:0] sel;
  logic [W-1:0]    saida;
  logic            valido;
  logic [N-1:0]    ack;

  modport slave (
    input  req, dado, pronto,
    output sel, saida, valido, ack
  );

  modport master (
    output req, dado, pronto,
    input  sel, saida, valido, ack
  );

endinterface

// File: rtl/arbitro_rr_mux16_codificador_prio_rr.sv
// Rotating priority encoder: first set bit of req searching from ptr upward with wrap.
// Purely combinational, no backpressure.
module codificador_prio_rr
  import arbitro_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] off;

  // Scanning downward leaves the smallest distance from ptr in off.
  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[SELW'(ptr + SELW'(j))]) begin
        off = SELW'(j);
      end
    end
    idx = ptr + off;
    any = |req;
  end

endmodule

// File: rtl/arbitro_rr_mux16.sv
// Round-robin 16:1 x 12-bit mux: grant registered one edge after req, word held until pronto.
// Backpressure: pronto=0 holds sel/saida/valido indefinitely; ack pulses combinationally on accept.
module arbitro_rr_mux16
  import arbitro_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  arbitro_rr_mux16_if.slave  bus
);

  estado_t         estado, estado_prox;
  logic [SELW-1:0] ptr, ptr_prox;
  logic [SELW-1:0] sel_q, sel_prox;
  logic [W-1:0]    saida_q, saida_prox;
  logic [SELW-1:0] idx;
  logic            any;
  logic            valido;

  codificador_prio_rr u_codificador (
    .req (bus.req),
    .ptr (ptr),
    .idx (idx),
    .any (any)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado  <= OCIOSO;
      ptr     <= '0;
      sel_q   <= '0;
      saida_q <= '0;
    end else begin
      estado  <= estado_prox;
      ptr     <= ptr_prox;
      sel_q   <= sel_prox;
      saida_q <= saida_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    ptr_prox    = ptr;
    sel_prox    = sel_q;
    saida_prox  = saida_q;
    case (estado)
      OCIOSO: begin
        if (any) begin
          sel_prox    = idx;
          saida_prox  = palavra(bus.dado, idx);
          estado_prox = ENVIA;
        end
      end
      ENVIA: begin
        // The winner moves to lowest priority once its word is taken.
        if (bus.pronto) begin
          ptr_prox    = sel_q + 1'b1;
          estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  assign valido     = (estado == ENVIA);
  assign bus.valido = valido;
  assign bus.sel    = sel_q;
  assign bus.saida  = saida_q;
  // A reset edge aborts the transfer, so no acknowledge may leak out in that cycle.
  assign bus.ack    = (valido && bus.pronto && reset) ? ({{(N-1){1'b0}}, 1'b1} << sel_q) : '0;

endmodule

// File: tb/tb_arbitro_rr_mux16.sv
// Bench for arbitro_rr_mux16: transfer-level reference model plus directed literal checks.
module tb_arbitro_rr_mux16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  arbitro_rr_mux16_if bus ();

  arbitro_rr_mux16 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit armed       = 1'b0;

  // Reference: one pending transfer at most, pointer advances past each served source.
  bit        m_valid = 1'b0;
  int        m_sel   = 0;
  logic [11:0] m_saida = '0;
  int        m_ptr   = 0;

  logic [15:0] ackq[$];
  int          ackt[$];

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_saida = '0;
      m_ptr   = 0;
    end else if (m_valid) begin
      if (bus.pronto) begin
        m_valid = 1'b0;
        m_ptr   = (m_sel + 1) % 16;
      end
    end else if (bus.req != 16'h0) begin
      for (int k = 0; k < 16; k++) begin
        int src;
        src = (m_ptr + k) % 16;
        if (bus.req[src]) begin
          m_sel   = src;
          m_saida = bus.dado[src*12 +: 12];
          m_valid = 1'b1;
          break;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      logic [15:0] exp_ack;
      exp_ack = (m_valid && bus.pronto && reset) ? (16'h1 << m_sel) : 16'h0;
      vectors++;
      if (bus.valido !== m_valid || bus.sel !== 4'(m_sel) ||
          bus.saida !== m_saida || bus.ack !== exp_ack) begin
        miscompares++;
        $display("FAIL model cyc=%0d: got valido=%b sel=%0d saida=%h ack=%h, need valido=%b sel=%0d saida=%h ack=%h",
                 cyc, bus.valido, bus.sel, bus.saida, bus.ack,
                 m_valid, m_sel, m_saida, exp_ack);
      end
      if (bus.ack != 16'h0) begin
        ackq.push_back(bus.ack);
        ackt.push_back(cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_word(input int i, input logic [11:0] v);
    bus.dado[i*12 +: 12] = v;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    bus.req    = '0;
    bus.pronto = 1'b0;
    tick();
    armed = 1'b1;
    tick();
    chk("rst_valido", 32'(bus.valido), 32'd0);
    chk("rst_sel",    32'(bus.sel),    32'd0);
    chk("rst_saida",  32'(bus.saida),  32'd0);
    chk("rst_ack",    32'(bus.ack),    32'd0);
    reset = 1'b1;
    ackq.delete();
    ackt.delete();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int t;
    t = 0;
    while (ackq.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (ackq.size() < n) begin
      miscompares++;
      $display("FAIL wait_acks: got %0d acks, need %0d", ackq.size(), n);
    end
  endtask

  initial begin
    bus.req    = '0;
    bus.dado   = '0;
    bus.pronto = 1'b0;

    // Single source, immediate accept, then pointer moved to 1.
    do_reset();
    set_word(0, 12'hABC);
    set_word(1, 12'h111);
    bus.req    = 16'h0001;
    bus.pronto = 1'b1;
    tick();
    chk("t1_valido", 32'(bus.valido), 32'd1);
    chk("t1_sel",    32'(bus.sel),    32'd0);
    chk("t1_saida",  32'(bus.saida),  32'hABC);
    chk("t1_ack",    32'(bus.ack),    32'h0001);
    bus.req = 16'h0000;
    tick();
    chk("t1_valido_fall", 32'(bus.valido), 32'd0);
    chk("t1_ack_once",    32'(bus.ack),    32'd0);
    chk("t1_saida_hold",  32'(bus.saida),  32'hABC);
    bus.req = 16'h0003;
    tick();
    chk("t1_ptr1_sel", 32'(bus.sel), 32'd1);
    bus.req = 16'h0000;
    tick();

    // Captured data survives dado change and long stall.
    bus.pronto = 1'b0;
    set_word(3, 12'h123);
    bus.req = 16'h0008;
    tick();
    chk("t4_sel",   32'(bus.sel),   32'd3);
    chk("t4_saida", 32'(bus.saida), 32'h123);
    set_word(3, 12'h456);
    bus.req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_saida", 32'(bus.saida), 32'h123);
      chk("t4_stall_ack",   32'(bus.ack),   32'h0);
    end
    bus.pronto = 1'b1;
    #1;
    chk("t4_ack", 32'(bus.ack), 32'h0008);
    tick();
    chk("t4_valido_fall", 32'(bus.valido), 32'd0);
    bus.pronto = 1'b0;

    // Dropping req during ENVIA does not retract the grant.
    set_word(5, 12'h5A5);
    bus.req = 16'h0020;
    tick();
    chk("t5_sel", 32'(bus.sel), 32'd5);
    bus.req = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_valido", 32'(bus.valido), 32'd1);
      chk("t5_hold_sel",    32'(bus.sel),    32'd5);
    end
    bus.pronto = 1'b1;
    #1;
    chk("t5_ack", 32'(bus.ack), 32'h0020);
    tick();
    chk("t5_valido_fall", 32'(bus.valido), 32'd0);
    bus.pronto = 1'b0;

    // Reset during ENVIA aborts with no ack and rewinds the pointer.
    set_word(7, 12'h7E7);
    bus.req = 16'h0080;
    tick();
    chk("t6_sel", 32'(bus.sel), 32'd7);
    reset      = 1'b0;
    bus.pronto = 1'b1;
    #1;
    chk("t6_abort_ack", 32'(bus.ack), 32'h0);
    tick();
    reset      = 1'b1;
    bus.req    = 16'h0081;
    bus.pronto = 1'b0;
    #1;
    chk("t6_valido", 32'(bus.valido), 32'd0);
    chk("t6_sel0",   32'(bus.sel),    32'd0);
    chk("t6_saida0", 32'(bus.saida),  32'd0);
    chk("t6_ack0",   32'(bus.ack),    32'd0);
    tick();
    chk("t6_regrant_valido", 32'(bus.valido), 32'd1);
    chk("t6_regrant_sel",    32'(bus.sel),    32'd0);
    bus.req    = 16'h0000;
    bus.pronto = 1'b1;
    tick();

    // All requesting: strict rotation, one ack every 2 cycles.
    do_reset();
    for (int i = 0; i < 16; i++) set_word(i, 12'(16'h100 + i));
    bus.req    = 16'hFFFF;
    bus.pronto = 1'b1;
    wait_acks(32, 200);
    bus.req = 16'h0000;
    if (ackq.size() >= 32) begin
      logic [15:0] seen;
      int total;
      seen  = '0;
      total = 0;
      for (int k = 0; k < 17; k++) chk("t2_order", 32'(ackq[k]), 32'(16'h1 << (k % 16)));
      for (int k = 0; k < 16; k++) begin
        seen  = seen | ackq[k];
        total = total + $countones(ackq[k]);
      end
      chk("t2_cover", 32'(seen), 32'hFFFF);
      chk("t2_once",  32'(total), 32'd16);
      for (int k = 1; k < 32; k++) chk("t2_gap", 32'(ackt[k] - ackt[k-1]), 32'd2);
    end
    tick();

    // Wrap-around: pointer at 15 serves 15 then 0.
    do_reset();
    bus.req    = 16'hFFFF;
    bus.pronto = 1'b1;
    wait_acks(15, 100);
    bus.req = 16'h8001;
    wait_acks(17, 20);
    if (ackq.size() >= 17) begin
      chk("t3_last14", 32'(ackq[14]), 32'h4000);
      chk("t3_first",  32'(ackq[15]), 32'h8000);
      chk("t3_wrap",   32'(ackq[16]), 32'h0001);
    end
    bus.req = 16'h0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
